// File: rtl/neuron_select_sequencer.sv
// One-hot neuron select driver with direct index load and masked auto-scan.
// The scan holds each selected neuron for dwell+1 cycles and strobes the readout in the last of them.
module neuron_select_sequencer #(
  parameter int N_NEURONS = 8,
  parameter int ID_W      = $clog2(N_NEURONS),
  parameter int DWELL_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [ID_W-1:0]      id_in,
  input  logic                 id_valid,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [N_NEURONS-1:0] mask,
  output logic [N_NEURONS-1:0] neuron_select,
  output logic [ID_W-1:0]      cur_id,
  output logic                 busy,
  output logic                 sample_stb,
  output logic                 done
);

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_NEURONS);

  state_e               state_q;
  logic [N_NEURONS-1:0] sel_q;
  logic [N_NEURONS-1:0] mask_q;
  logic [ID_W-1:0]      cur_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 busy_q;
  logic                 done_q;

  logic [ID_W:0]        first_hit;
  logic [ID_W:0]        next_hit;
  logic                 id_ok;

  function automatic logic [N_NEURONS-1:0] onehot(input logic [ID_W-1:0] id);
    onehot = {{(N_NEURONS-1){1'b0}}, 1'b1} << id;
  endfunction

  // Lowest set bit of m at or above index lo; MSB of the result flags a hit.
  function automatic logic [ID_W:0] find_set(input logic [N_NEURONS-1:0] m,
                                             input logic [ID_W:0]      lo);
    logic [ID_W:0] r;
    r = '0;
    for (int k = N_NEURONS - 1; k >= 0; k--) begin
      if (m[k] && (k >= int'(lo))) r = {1'b1, ID_W'(k)};
    end
    return r;
  endfunction

  assign first_hit = find_set(mask, '0);
  assign next_hit  = find_set(mask_q, {1'b0, cur_q} + (ID_W+1)'(1));
  assign id_ok     = ({1'b0, id_in} < N_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= {{(N_NEURONS-1){1'b0}}, 1'b1};
      cur_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mode && start) begin
            mask_q  <= mask;
            dwell_q <= dwell;
            if (!first_hit[ID_W]) begin
              done_q <= 1'b1;
            end else begin
              state_q <= SCAN;
              busy_q  <= 1'b1;
              cur_q   <= first_hit[ID_W-1:0];
              sel_q   <= onehot(first_hit[ID_W-1:0]);
              cnt_q   <= dwell;
            end
          end else if (!mode && id_valid) begin
            cur_q <= id_ok ? id_in : '0;
            sel_q <= onehot(id_ok ? id_in : '0);
          end
        end
        SCAN: begin
          // Abort beats both the dwell countdown and the advance to the next neuron.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else if (next_hit[ID_W]) begin
            cur_q <= next_hit[ID_W-1:0];
            sel_q <= onehot(next_hit[ID_W-1:0]);
            cnt_q <= dwell_q;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign neuron_select = sel_q;
  assign cur_id        = cur_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sample_stb    = (state_q == SCAN) && (cnt_q == '0);

endmodule

// File: tb/tb_neuron_select_sequencer.sv
// Bench for neuron_select_sequencer: direct loads, masked scans, abort, reset and disturbance.
// Expected scan traces are built from the mask/dwell rules as a list of (neuron, strobe) per cycle.
module tb_neuron_select_sequencer;

  logic       clk = 1'b0;
  logic       rst, mode, id_valid, start, abort;
  logic [2:0] id_in;
  logic [7:0] dwell, mask;
  logic [7:0] neuron_select;
  logic [2:0] cur_id;
  logic       busy, sample_stb, done;

  logic [2:0] id6;
  logic       idv6;
  logic [5:0] sel6;
  logic [2:0] cur6;
  logic       busy6, stb6, done6;

  int vecs = 0;
  int errs = 0;
  int model_id = 0;

  always #5 clk = ~clk;

  neuron_select_sequencer #(.N_NEURONS(8), .ID_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .id_in(id_in), .id_valid(id_valid),
    .start(start), .abort(abort), .dwell(dwell), .mask(mask),
    .neuron_select(neuron_select), .cur_id(cur_id), .busy(busy),
    .sample_stb(sample_stb), .done(done)
  );

  neuron_select_sequencer #(.N_NEURONS(6), .ID_W(3), .DWELL_W(8)) dut6 (
    .clk(clk), .rst(rst), .mode(1'b0), .id_in(id6), .id_valid(idv6),
    .start(1'b0), .abort(1'b0), .dwell(8'd0), .mask(6'd0),
    .neuron_select(sel6), .cur_id(cur6), .busy(busy6),
    .sample_stb(stb6), .done(done6)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b0; id_valid = 1'b0; start = 1'b0; abort = 1'b0;
    id_in = '0; dwell = '0; mask = '0; id6 = '0; idv6 = 1'b0;
    #12;
    vecs++;
    if ({neuron_select, cur_id, busy, sample_stb, done} !== {8'h01, 3'd0, 3'b000}) begin
      errs++;
      $display("FAIL reset got sel=%h id=%0d b/s/d=%b%b%b exp sel=01 id=0 b/s/d=000",
               neuron_select, cur_id, busy, sample_stb, done);
    end
    vecs++;
    if ({sel6, cur6} !== {6'h01, 3'd0}) begin
      errs++;
      $display("FAIL reset6 got sel=%h id=%0d exp sel=01 id=0", sel6, cur6);
    end
    step;
    rst = 1'b0;
    model_id = 0;
  endtask

  task automatic test_direct;
    for (int n = 0; n < 18; n++) begin
      int v;
      v = (n < 8) ? n : int'($urandom_range(0, 7));
      id_in = 3'(v); id_valid = 1'b1;
      step;
      id_valid = 1'b0;
      model_id = v;
      vecs++;
      if ({neuron_select, cur_id, busy} !== {8'(1 << v), 3'(v), 1'b0}) begin
        errs++;
        $display("FAIL direct[%0d] got sel=%h id=%0d busy=%b exp sel=%h id=%0d busy=0",
                 v, neuron_select, cur_id, busy, 8'(1 << v), v);
      end
    end
    // start with mode=0 and abort in IDLE must not disturb anything
    mode = 1'b0; start = 1'b1; abort = 1'b1; mask = 8'hFF; id_in = 3'd1;
    step;
    start = 1'b0; abort = 1'b0;
    step;
    vecs++;
    if ({neuron_select, busy, done, sample_stb} !== {8'(1 << model_id), 3'b000}) begin
      errs++;
      $display("FAIL direct_ignore got sel=%h b/d/s=%b%b%b exp sel=%h b/d/s=000",
               neuron_select, busy, done, sample_stb, 8'(1 << model_id));
    end
  endtask

  task automatic test_direct_range;
    for (int v = 0; v < 8; v++) begin
      int e;
      e = (v < 6) ? v : 0;
      id6 = 3'(v); idv6 = 1'b1;
      step;
      idv6 = 1'b0;
      vecs++;
      if ({sel6, cur6} !== {6'(1 << e), 3'(e)}) begin
        errs++;
        $display("FAIL direct6[%0d] got sel=%h id=%0d exp sel=%h id=%0d",
                 v, sel6, cur6, 6'(1 << e), e);
      end
    end
  endtask

  // Leaves the bench in the cycle right after the scan ends (done cycle for a full run).
  task automatic run_scan(input logic [7:0] m, input logic [7:0] dw,
                          input bit disturb, input int abort_at);
    int  q_id[$];
    bit  q_stb[$];
    int  last;
    bit  aborted;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        for (int c = 0; c <= int'(dw); c++) begin
          q_id.push_back(k);
          q_stb.push_back(c == int'(dw));
        end
      end
    end
    aborted = 1'b0;
    mode = 1'b1; start = 1'b1; id_valid = 1'b0; mask = m; dwell = dw;
    step;
    start = 1'b0;
    last = q_id[q_id.size() - 1];
    for (int i = 0; i < q_id.size(); i++) begin
      vecs++;
      if ({busy, cur_id, neuron_select, sample_stb, done} !==
          {1'b1, 3'(q_id[i]), 8'(1 << q_id[i]), q_stb[i], 1'b0}) begin
        errs++;
        $display("FAIL scan m=%h dw=%0d cyc=%0d got busy=%b id=%0d sel=%h stb=%b done=%b exp busy=1 id=%0d sel=%h stb=%b done=0",
                 m, dw, i, busy, cur_id, neuron_select, sample_stb, done,
                 q_id[i], 8'(1 << q_id[i]), q_stb[i]);
      end
      if (disturb) begin
        id_valid = 1'($urandom); start = 1'($urandom); mode = 1'($urandom);
        mask = 8'($urandom); dwell = 8'($urandom); id_in = 3'($urandom);
      end
      if (i == abort_at) abort = 1'b1;
      step;
      abort = 1'b0;
      if (i == abort_at) begin
        aborted = 1'b1;
        last = q_id[i];
        break;
      end
    end
    mode = 1'b0; id_valid = 1'b0; start = 1'b0;
    model_id = last;
    vecs++;
    if ({busy, done, sample_stb, cur_id, neuron_select} !==
        {1'b0, !aborted, 1'b0, 3'(last), 8'(1 << last)}) begin
      errs++;
      $display("FAIL scan_end m=%h dw=%0d got busy=%b done=%b stb=%b id=%0d sel=%h exp busy=0 done=%b stb=0 id=%0d sel=%h",
               m, dw, busy, done, sample_stb, cur_id, neuron_select, !aborted, last, 8'(1 << last));
    end
  endtask

  task automatic test_quiet(input string nm);
    step;
    vecs++;
    if ({busy, done, sample_stb, neuron_select} !== {3'b000, 8'(1 << model_id)}) begin
      errs++;
      $display("FAIL %s_after got b/d/s=%b%b%b sel=%h exp b/d/s=000 sel=%h",
               nm, busy, done, sample_stb, neuron_select, 8'(1 << model_id));
    end
  endtask

  task automatic test_scan_basic;
    run_scan(8'hA5, 8'd2, 1'b0, -1);
    test_quiet("basic");
    run_scan(8'hFF, 8'd0, 1'b0, -1);
    test_quiet("dwell0");
  endtask

  task automatic test_scan_empty;
    mode = 1'b1; start = 1'b1; mask = 8'h00; dwell = 8'd5;
    step;
    start = 1'b0; mode = 1'b0;
    vecs++;
    if ({busy, done, neuron_select} !== {1'b0, 1'b1, 8'(1 << model_id)}) begin
      errs++;
      $display("FAIL empty got busy=%b done=%b sel=%h exp busy=0 done=1 sel=%h",
               busy, done, neuron_select, 8'(1 << model_id));
    end
    test_quiet("empty");
  endtask

  task automatic test_disturb;
    run_scan(8'hA5, 8'd2, 1'b1, -1);
    test_quiet("disturb");
    run_scan(8'h3C, 8'd1, 1'b1, -1);
    test_quiet("disturb2");
  endtask

  task automatic test_abort;
    run_scan(8'h0F, 8'd3, 1'b0, 9);
    test_quiet("abort_mid");
    run_scan(8'h0F, 8'd3, 1'b0, 11);
    test_quiet("abort_stb");
  endtask

  task automatic test_back_to_back;
    run_scan(8'h81, 8'd1, 1'b0, -1);
    run_scan(8'h42, 8'd0, 1'b0, -1);
    run_scan(8'hA5, 8'd1, 1'b0, -1);
    test_quiet("b2b");
  endtask

  task automatic test_reset_mid;
    mode = 1'b1; start = 1'b1; mask = 8'hFE; dwell = 8'd3;
    step;
    start = 1'b0;
    step;
    step;
    rst = 1'b1;
    #1;
    vecs++;
    if ({neuron_select, cur_id, busy, sample_stb, done} !== {8'h01, 3'd0, 3'b000}) begin
      errs++;
      $display("FAIL reset_mid got sel=%h id=%0d b/s/d=%b%b%b exp sel=01 id=0 b/s/d=000",
               neuron_select, cur_id, busy, sample_stb, done);
    end
    step;
    rst = 1'b0; mode = 1'b0;
    model_id = 0;
    for (int i = 0; i < 4; i++) test_quiet("reset_mid");
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      logic [7:0] m;
      logic [7:0] dw;
      int len;
      int ab;
      m = 8'($urandom);
      while (m == 8'h00) m = 8'($urandom);
      dw = 8'($urandom_range(0, 4));
      len = $countones(m) * (int'(dw) + 1);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_scan(m, dw, 1'($urandom), ab);
      if ($urandom_range(0, 1) == 1) test_quiet("random");
    end
    test_quiet("random_end");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vecs=%0d exp completion", vecs);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_direct;
    test_direct_range;
    test_scan_basic;
    test_scan_empty;
    test_disturb;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
